// File: rtl/dds_iq_mixer19.sv
// Quadrature mixer behind the dds2k19 synthesizer: one shared multiplier turns an interleaved
// X/Y word stream and one input sample into a rounded, saturated I/Q pair every two clocks.
// Optional MIXER_CONJ_EN adds a conj input that negates the quadrature output (opposite sideband).
module dds_iq_mixer19 #(
    parameter int IW = 16,
    parameter int DW = 19,
    parameter int OW = 18
) (
    input  logic          dclk,
    input  logic          rst_n,
    input  logic          iq,
    input  logic [DW-1:0] doxy,
    input  logic [IW-1:0] din,
`ifdef MIXER_CONJ_EN
    input  logic          conj,
`endif
    output logic [OW-1:0] i_out,
    output logic [OW-1:0] q_out,
    output logic          vld
);

    localparam int PW = IW + DW;
    localparam int SH = PW - 1 - OW;
    localparam int RW = PW + 1;

    localparam logic signed [RW-1:0] HALF = RW'(1) << (SH - 1);
    localparam logic signed [RW-1:0] RMAX = (RW'(1) << (OW - 1)) - RW'(1);
    localparam logic signed [RW-1:0] RMIN = -(RW'(1) << (OW - 1));
    localparam logic signed [OW-1:0] OMAX = RMAX[OW-1:0];
    localparam logic signed [OW-1:0] OMIN = RMIN[OW-1:0];

    // pair framing
    logic [IW-1:0]        r_din_h;
    logic                 r_pair_open;

    // operand stage
    logic signed [DW-1:0] r_op_a;
    logic signed [IW-1:0] r_op_b;
    logic                 r_s1_vld;
    logic                 r_s1_y;

    // product stage
    logic signed [PW-1:0] r_prod;
    logic                 r_s2_vld;
    logic                 r_s2_y;

    // held X result waiting for its Y partner
    logic signed [OW-1:0] r_ri;

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [RW-1:0] w_sum;
    logic signed [RW-1:0] w_shr;
    logic signed [OW-1:0] w_rsat;
    logic signed [OW-1:0] w_q;

`ifdef MIXER_CONJ_EN
    logic                 r_conj_h;
    logic                 r_s1_conj;
    logic                 r_s2_conj;
    logic signed [OW-1:0] w_rneg;
`endif

    assign w_a_ext = PW'(r_op_a);
    assign w_b_ext = PW'(r_op_b);

    // round half toward +inf, then clamp to the output range
    assign w_sum = $signed({r_prod[PW-1], r_prod}) + HALF;
    assign w_shr = w_sum >>> SH;

    always_comb begin
        w_rsat = w_shr[OW-1:0];
        if (w_shr > RMAX) begin
            w_rsat = OMAX;
        end else if (w_shr < RMIN) begin
            w_rsat = OMIN;
        end
    end

`ifdef MIXER_CONJ_EN
    // negating the most negative code would wrap, so it clamps to the positive limit
    assign w_rneg = (w_rsat == OMIN) ? OMAX : -w_rsat;
    assign w_q    = r_s2_conj ? w_rneg : w_rsat;
`else
    assign w_q    = w_rsat;
`endif

    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_din_h     <= '0;
            r_pair_open <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_y      <= 1'b0;
            r_prod      <= '0;
            r_s2_vld    <= 1'b0;
            r_s2_y      <= 1'b0;
            r_ri        <= '0;
            i_out       <= '0;
            q_out       <= '0;
            vld         <= 1'b0;
`ifdef MIXER_CONJ_EN
            r_conj_h    <= 1'b0;
            r_s1_conj   <= 1'b0;
            r_s2_conj   <= 1'b0;
`endif
        end else begin
            // X edge always (re)opens a pair; Y edge only counts if a pair is open
            if (iq) begin
                r_op_a      <= doxy;
                r_op_b      <= din;
                r_din_h     <= din;
                r_pair_open <= 1'b1;
                r_s1_vld    <= 1'b1;
                r_s1_y      <= 1'b0;
`ifdef MIXER_CONJ_EN
                r_conj_h    <= conj;
`endif
            end else if (r_pair_open) begin
                r_op_a      <= doxy;
                r_op_b      <= r_din_h;
                r_pair_open <= 1'b0;
                r_s1_vld    <= 1'b1;
                r_s1_y      <= 1'b1;
`ifdef MIXER_CONJ_EN
                r_s1_conj   <= r_conj_h;
`endif
            end else begin
                r_s1_vld    <= 1'b0;
            end

            r_prod   <= w_a_ext * w_b_ext;
            r_s2_vld <= r_s1_vld;
            r_s2_y   <= r_s1_y;
`ifdef MIXER_CONJ_EN
            r_s2_conj <= r_s1_conj;
`endif

            vld <= 1'b0;
            if (r_s2_vld) begin
                if (!r_s2_y) begin
                    r_ri <= w_rsat;
                end else begin
                    i_out <= r_ri;
                    q_out <= w_q;
                    vld   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_iq_mixer19.sv
// Self-checking bench for dds_iq_mixer19: vector table plus framing/reset sequences,
// expected I/Q pushed to a scoreboard at the Y edge and popped on each vld.
module tb_dds_iq_mixer19;

    logic        dclk;
    logic        rst_n;
    logic        iq;
    logic [18:0] doxy;
    logic [15:0] din;
    logic [17:0] i_out;
    logic [17:0] q_out;
    logic        vld;

    dds_iq_mixer19 dut (
        .dclk  (dclk),
        .rst_n (rst_n),
        .iq    (iq),
        .doxy  (doxy),
        .din   (din),
`ifdef MIXER_CONJ_EN
        .conj  (1'b0),
`endif
        .i_out (i_out),
        .q_out (q_out),
        .vld   (vld)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    int cyc = 0;
    always @(posedge dclk) cyc <= cyc + 1;

    typedef struct {
        logic signed [17:0] ei;
        logic signed [17:0] eq;
        int                 cyc;
    } exp_t;

    typedef struct {
        int                 d;
        int                 x;
        int                 y;
        logic signed [17:0] ei;
        logic signed [17:0] eq;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vt[7];

    int total = 0;
    int bad   = 0;
    logic               mon_en = 1'b0;
    logic               s_mode = 1'b0;
    logic signed [17:0] hold_i = '0;
    logic signed [17:0] hold_q = '0;
    int                 xc;

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic logic signed [17:0] mdl(input int d, input int x);
        longint p;
        longint r;
        p = longint'(d) * longint'(x);
        r = (p + 64'sd32768) >>> 16;
        if (r > 131071)  r = 131071;
        if (r < -131072) r = -131072;
        return 18'(r);
    endfunction

    task automatic step(input logic q, input int x, input int d);
        iq   = q;
        doxy = 19'(x);
        din  = 16'(d);
        @(posedge dclk);
        #1;
    endtask

    task automatic do_pair(input int d, input int x, input int y,
                           input logic signed [17:0] ei, input logic signed [17:0] eq);
        exp_t t;
        step(1'b1, x, d);
        xc = cyc;
        step(1'b0, y, int'($urandom));
        t.ei  = ei;
        t.eq  = eq;
        t.cyc = xc + 3;
        sb.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, int'($urandom), int'($urandom));
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) begin
            step(1'($urandom), int'($urandom), int'($urandom));
            hold_i = '0;
            hold_q = '0;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        real ang;
        int  x;
        int  y;
        longint mi;
        longint mq;
        longint m;
        longint rf;

        rf = 131067;
        rf = rf * rf;

        vt[0] = '{16384,   262143,      0,   18'sd65536,       18'sd0};
        vt[1] = '{-16384,  0,      262143,   18'sd0,          -18'sd65536};
        vt[2] = '{1,       1,          -1,   18'sd0,           18'sd0};
        vt[3] = '{-32768, -262144, -262144,  18'sd131071,      18'sd131071};
        vt[4] = '{32767,   131072, -131072,  18'sd65534,      -18'sd65534};
        vt[5] = '{1,       32768,  -32768,   18'sd1,           18'sd0};
        vt[6] = '{-1,     -98304,   98304,   18'sd2,          -18'sd1};

        fork
            forever begin
                @(negedge dclk);
                if (mon_en) begin
                    if (vld) begin
                        if (sb.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_vld i_out=%0d q_out=%0d required=no vld (t=%0t)",
                                     $signed(i_out), $signed(q_out), $time);
                        end else begin
                            e = sb.pop_front();
                            check("vld_latency", cyc, e.cyc);
                            check("i_out", int'($signed(i_out)), int'(e.ei));
                            check("q_out", int'($signed(q_out)), int'(e.eq));
                            hold_i = e.ei;
                            hold_q = e.eq;
                            if (s_mode) begin
                                mi = longint'($signed(i_out));
                                mq = longint'($signed(q_out));
                                m  = mi * mi + mq * mq;
                                total++;
                                if (m * 100 < rf * 99 || m * 100 > rf * 101) begin
                                    bad++;
                                    $display("FAIL magnitude actual=%0d required=%0d+-1%%", m, rf);
                                end
                            end
                        end
                    end else begin
                        check("hold_i", int'($signed(i_out)), int'(hold_i));
                        check("hold_q", int'($signed(q_out)), int'(hold_q));
                    end
                end
            end
        join_none

        // reset with random activity on the inputs
        rst_n = 1'b0;
        iq    = 1'b0;
        doxy  = '0;
        din   = '0;
        @(posedge dclk);
        #1;
        mon_en = 1'b1;
        do_reset(4);

        // lone iq=0 edges straight after reset must be ignored
        idle(4);

        for (int i = 0; i < 7; i++) begin
            do_pair(vt[i].d, vt[i].x, vt[i].y, vt[i].ei, vt[i].eq);
        end
        idle(6);

        // framing: 1,1,0,0 -> one vld from the second X, extra iq=0 ignored
        step(1'b1, 1000, 32767);
        step(1'b1, 2000, 32767);
        xc = cyc;
        step(1'b0, 500, 0);
        e.ei = 18'sd1000;
        e.eq = 18'sd250;
        e.cyc = xc + 3;
        sb.push_back(e);
        step(1'b0, 7777, 4321);
        idle(6);

        // reset between X and Y: the later iq=0 must not complete a pair
        step(1'b1, 100000, 20000);
        do_reset(1);
        step(1'b0, 100000, 20000);
        idle(6);

        // reset while a complete pair is still in flight
        step(1'b1, 5000, 1234);
        step(1'b0, 6000, 1234);
        do_reset(1);
        idle(6);

        // recovery after reset
        do_pair(-20000, 200000, -150000, mdl(-20000, 200000), mdl(-20000, -150000));
        idle(6);

        // streaming sinusoid, back-to-back pairs
        s_mode = 1'b1;
        for (int k = 0; k < 512; k++) begin
            ang = 2.0 * 3.14159265358979 * real'(k) / 64.0;
            x = int'(262143.0 * $cos(ang));
            y = int'(262143.0 * $sin(ang));
            do_pair(32767, x, y, mdl(32767, x), mdl(32767, y));
        end
        idle(6);
        s_mode = 1'b0;

        check("scoreboard_empty", sb.size(), 0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_iq_mixer19.md
Name: dds_iq_mixer19

Overview:
- Quadrature mixer directly downstream of the dds2k19 synthesizer.
- Consumes the DDS interleaved 19-bit X/Y (cos/sin) stream on doxy, phased by iq.
- Multiplies each X/Y pair by one signed input sample using a single time-shared multiplier.
- Emits a rounded, saturated I/Q pair once per two-clock sample period to the downstream decimation filters.

Parameters:
- IW, 16, signed input sample width (din).
- DW, 19, signed DDS word width (doxy).
- OW, 18, signed output width of i_out/q_out.

Ports:
- dclk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- iq  in  1  phase strobe. 1 = doxy carries X (cos); 0 = doxy carries Y (sin).
- doxy  in  DW  interleaved DDS output, two's complement.
- din  in  IW  input sample, two's complement. Sampled only on iq=1 edges.
- i_out  out  OW  in-phase product, din*X.
- q_out  out  OW  quadrature product, din*Y.
- vld  out  1  one-cycle pulse; i_out/q_out updated on the same edge.

Behaviour:
- Reset: while rst_n=0 at an edge, clear all pipeline regs and pair-tracking state. i_out=0, q_out=0, vld=0.
- Pair framing:
  - Edge n with iq=1: capture doxy→opA and din→opB. Hold din in din_h. Set pair_open=1.
  - Edge n+1 with iq=0 and pair_open=1: capture doxy→opA, din_h→opB, tag=Y. Clear pair_open.
- Product: p = opA*opB, signed, PW=IW+DW bits, registered one edge after operand capture.
- Round/saturate, registered one edge after p:
  - r = (p + 2^(PW-2-OW)) >>> (PW-1-OW). Round half toward +inf.
  - If r > 2^(OW-1)-1, set r = 2^(OW-1)-1. If r < -2^(OW-1), set r = -2^(OW-1).
  - With defaults, the output is p[33:16] rounded; the only overflow is (-32768)*(-262144).
- Output: X result is held in ri. When the Y result is registered, at edge n+3:
  - i_out<=ri, q_out<=rY, vld<=1.
  - vld returns to 0 at the next edge.
- Latency: 3 edges from the X capture edge to the edge that asserts vld. Throughput: one pair per 2 clocks.
- i_out/q_out hold their value between vld pulses.
- Boundaries:
  - iq=1 on two consecutive edges: the later edge restarts the pair. The earlier X is discarded and no vld is produced for it.
  - iq=0 with pair_open=0, including the first edge after reset or a repeated iq=0: doxy is ignored and nothing enters the pipeline.
  - rst_n deasserted mid-pair or mid-pipeline: all in-flight results are dropped. The first vld after release requires a complete new X,Y pair.
  - Products already in the pipeline always complete. A pair restart discards only the incomplete pair.

Optional Feature:
- Macro MIXER_CONJ_EN.
- When defined:
  - Adds input port conj (1 bit), sampled with din on the iq=1 edge and carried through the pipeline with the pair.
  - If conj=1, q_out = -rY. A negated value of -2^(OW-1) saturates to 2^(OW-1)-1.
  - Selects the opposite sideband.
- When undefined:
  - No conj port.
  - q_out = rY always, with identical latency.

Test Plan:
- Reset: hold rst_n=0 for 4 edges with random doxy/din → i_out=0, q_out=0, vld=0 throughout. After release, no vld until a full pair is presented.
- Basic: din=16384, X=262143, Y=0 → vld 3 edges after the X edge; i_out=65536, q_out=0.
- Sign/rounding: din=-16384, X=0, Y=262143 → i_out=0, q_out=-65536. Also din=1, X=1, Y=-1 → i_out=0, q_out=0.
- Saturation: din=-32768, X=-262144, Y=-262144 → i_out=131071, q_out=131071, with no wrap to negative.
- Framing: iq sequence 1,1,0 with X values 1000 then 2000 and din=32767 → exactly one vld; i_out reflects X=2000 (round(32767*2000/65536)=1000). A lone iq=0 edge produces no vld.
- Streaming: 16400 consecutive pairs from dds2k19 with frq=32'h00040000 and din=32767 → vld every 2nd edge. i_out^2+q_out^2 stays within 1% of constant, and one full cycle spans 16384 samples.
